// File: rtl/rvga_types_pkg.sv
// rvga_types_pkg: shared RV32I decode types.
//   rvga_reg        5-bit register specifier
//   rvga_word       32-bit data word
//   rvga_op_e       decoded operation class (ILLEGAL is encoding 0)
//   OPC_*           7-bit major opcodes
//   rvga_decoded_s  decoded instruction bundle
//   rvga_opcode_to_op / rvga_writes_rd  decode helpers
package rvga_types_pkg;

    typedef logic [4:0]  rvga_reg;
    typedef logic [31:0] rvga_word;

    typedef enum logic [3:0] {
        OP_ILLEGAL = 4'd0,
        OP_LUI     = 4'd1,
        OP_AUIPC   = 4'd2,
        OP_JAL     = 4'd3,
        OP_JALR    = 4'd4,
        OP_BRANCH  = 4'd5,
        OP_LOAD    = 4'd6,
        OP_STORE   = 4'd7,
        OP_OPIMM   = 4'd8,
        OP_OP      = 4'd9,
        OP_FENCE   = 4'd10,
        OP_SYSTEM  = 4'd11
    } rvga_op_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        rvga_word   pc;
        rvga_op_e   op;
        logic [2:0] funct3;
        logic       funct7b5;
        rvga_reg    rs1;
        rvga_reg    rs2;
        rvga_reg    rd;
        logic       rd_w_v;
        rvga_word   imm;
        logic       illegal;
    } rvga_decoded_s;

    // Any opcode whose low two bits are not 2'b11 misses every constant
    // above and falls into the ILLEGAL class.
    function automatic rvga_op_e rvga_opcode_to_op(input logic [6:0] opc);
        rvga_op_e op;
        case (opc)
            OPC_LUI:    op = OP_LUI;
            OPC_AUIPC:  op = OP_AUIPC;
            OPC_JAL:    op = OP_JAL;
            OPC_JALR:   op = OP_JALR;
            OPC_BRANCH: op = OP_BRANCH;
            OPC_LOAD:   op = OP_LOAD;
            OPC_STORE:  op = OP_STORE;
            OPC_OPIMM:  op = OP_OPIMM;
            OPC_OP:     op = OP_OP;
            OPC_FENCE:  op = OP_FENCE;
            OPC_SYSTEM: op = OP_SYSTEM;
            default:    op = OP_ILLEGAL;
        endcase
        return op;
    endfunction

    function automatic logic rvga_writes_rd(input rvga_op_e op);
        return (op == OP_LUI)  || (op == OP_AUIPC) || (op == OP_JAL) ||
               (op == OP_JALR) || (op == OP_LOAD)  || (op == OP_OPIMM) ||
               (op == OP_OP);
    endfunction

endpackage

// File: rtl/rdecode_imm_gen.sv
// rdecode_imm_gen: purely combinational RV32I immediate generator.
//   instr_i  in  32  raw instruction word
//   imm_o    out 32  immediate for the instruction's format, sign-extended
//                    from instr[31]; 0 for R-type, FENCE, SYSTEM, illegal
module rdecode_imm_gen
    import rvga_types_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [31:0] imm_o
);

    logic signed [31:0] imm_i_fmt;
    logic signed [31:0] imm_s_fmt;
    logic signed [31:0] imm_b_fmt;
    logic signed [31:0] imm_u_fmt;
    logic signed [31:0] imm_j_fmt;

    assign imm_i_fmt = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s_fmt = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b_fmt = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                        instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u_fmt = {instr_i[31:12], 12'b0};
    assign imm_j_fmt = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                        instr_i[20], instr_i[30:21], 1'b0};

    // Shift-immediates keep the plain I-format value; funct7 bits stay in it.
    always_comb begin
        imm_o = '0;
        case (instr_i[6:0])
            OPC_LUI, OPC_AUIPC:           imm_o = imm_u_fmt;
            OPC_JAL:                      imm_o = imm_j_fmt;
            OPC_JALR, OPC_LOAD, OPC_OPIMM: imm_o = imm_i_fmt;
            OPC_BRANCH:                   imm_o = imm_b_fmt;
            OPC_STORE:                    imm_o = imm_s_fmt;
            default:                      imm_o = '0;
        endcase
    end

endmodule

// File: rtl/rdecode_stage.sv
// rdecode_stage: registered RV32I decode stage between fetch and register fetch.
//   clk_i, rst_i                   clock, synchronous active-high reset
//   flush_i                        drop all held and incoming instructions
//   fetch_v_i / fetch_ready_o      upstream handshake
//   fetch_pc_i, fetch_instr_i      offered PC and instruction word
//   dec_v_o / dec_ready_i          downstream handshake
//   dec_pc_o, dec_op_o, dec_funct3_o, dec_funct7b5_o,
//   rs1_o, rs2_o, rd_o, rd_w_v_o, imm_o, illegal_o   decoded bundle
// Optional build macro RVGA_DECODE_SKID_EN adds a one-entry skid buffer so
// fetch_ready_o is a flop output with no path from dec_ready_i.
// pc_width_p must not exceed 32.
module rdecode_stage
    import rvga_types_pkg::*;
#(
    parameter int pc_width_p = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  fetch_v_i,
    output logic                  fetch_ready_o,
    input  logic [pc_width_p-1:0] fetch_pc_i,
    input  logic [31:0]           fetch_instr_i,
    output logic                  dec_v_o,
    input  logic                  dec_ready_i,
    output logic [pc_width_p-1:0] dec_pc_o,
    output rvga_op_e              dec_op_o,
    output logic [2:0]            dec_funct3_o,
    output logic                  dec_funct7b5_o,
    output rvga_reg               rs1_o,
    output rvga_reg               rs2_o,
    output rvga_reg               rd_o,
    output logic                  rd_w_v_o,
    output rvga_word              imm_o,
    output logic                  illegal_o
);

    rvga_decoded_s new_dec;
    rvga_word      new_imm;
    rvga_op_e      new_op;

    rvga_decoded_s main_q, main_d;
    logic          main_v_q, main_v_d;
    logic          accept;
    logic          drain;

    // ---- decode (combinational on the offered word) ----
    rdecode_imm_gen u_imm_gen (
        .instr_i (fetch_instr_i),
        .imm_o   (new_imm)
    );

    assign new_op = rvga_opcode_to_op(fetch_instr_i[6:0]);

    always_comb begin
        new_dec          = '0;
        new_dec.pc       = rvga_word'(fetch_pc_i);
        new_dec.op       = new_op;
        new_dec.funct3   = fetch_instr_i[14:12];
        new_dec.funct7b5 = fetch_instr_i[30];
        new_dec.rs1      = fetch_instr_i[19:15];
        new_dec.rs2      = fetch_instr_i[24:20];
        new_dec.rd       = fetch_instr_i[11:7];
        new_dec.rd_w_v   = rvga_writes_rd(new_op) && (fetch_instr_i[11:7] != 5'd0);
        new_dec.imm      = new_imm;
        new_dec.illegal  = (new_op == OP_ILLEGAL);
    end

    assign drain = main_v_q && dec_ready_i;

`ifdef RVGA_DECODE_SKID_EN
    rvga_decoded_s skid_q, skid_d;
    logic          skid_v_q, skid_v_d;

    // The skid can only be occupied while the main entry is, so a free skid
    // always leaves room for one more instruction.
    assign fetch_ready_o = !skid_v_q;
    assign accept        = fetch_v_i && fetch_ready_o;

    always_comb begin
        main_d   = main_q;
        main_v_d = main_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        if (drain) begin
            if (skid_v_q) begin
                main_d   = skid_q;
                skid_v_d = 1'b0;
            end else if (accept) begin
                main_d   = new_dec;
            end else begin
                main_v_d = 1'b0;
            end
        end else if (accept) begin
            if (main_v_q) begin
                skid_d   = new_dec;
                skid_v_d = 1'b1;
            end else begin
                main_d   = new_dec;
                main_v_d = 1'b1;
            end
        end
        if (flush_i) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end
    end

    // ---- skid register ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            skid_q   <= '0;
            skid_v_q <= 1'b0;
        end else begin
            skid_q   <= skid_d;
            skid_v_q <= skid_v_d;
        end
    end
`else
    assign fetch_ready_o = !main_v_q || dec_ready_i;
    assign accept        = fetch_v_i && fetch_ready_o;

    always_comb begin
        main_d   = main_q;
        main_v_d = main_v_q;
        if (accept) begin
            main_d   = new_dec;
            main_v_d = 1'b1;
        end else if (drain) begin
            main_v_d = 1'b0;
        end
        if (flush_i) begin
            main_v_d = 1'b0;
        end
    end
`endif

    // ---- main output register ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_q   <= '0;
            main_v_q <= 1'b0;
        end else begin
            main_q   <= main_d;
            main_v_q <= main_v_d;
        end
    end

    assign dec_v_o        = main_v_q;
    assign dec_pc_o       = main_q.pc[pc_width_p-1:0];
    assign dec_op_o       = main_q.op;
    assign dec_funct3_o   = main_q.funct3;
    assign dec_funct7b5_o = main_q.funct7b5;
    assign rs1_o          = main_q.rs1;
    assign rs2_o          = main_q.rs2;
    assign rd_o           = main_q.rd;
    assign rd_w_v_o       = main_q.rd_w_v;
    assign imm_o          = main_q.imm;
    assign illegal_o      = main_q.illegal;

endmodule

// File: doc/rdecode_stage.md
Name: rdecode_stage

Overview:
Decode stage sitting directly upstream of the register-fetch datapath. It accepts fetched RV32I instructions over a valid/ready handshake and decodes them into a registered bundle: operation class, register specifiers, sign-extended immediate, and funct fields. The registered rs1/rs2 fields drive the register-fetch read addresses, and the whole bundle is handed downstream with valid/ready. It supports a pipeline flush from branch/jump resolution.

Parameters:
pc_width_p, 32, width of program counter carried with each instruction

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
flush_i  in  1  discard all held and incoming instructions
fetch_v_i  in  1  fetch offers an instruction
fetch_ready_o  out  1  stage can accept this cycle
fetch_pc_i  in  pc_width_p  PC of offered instruction
fetch_instr_i  in  32  raw instruction word
dec_v_o  out  1  decoded bundle valid
dec_ready_i  in  1  downstream (rfetch/execute) accepts
dec_pc_o  out  pc_width_p  PC of bundle
dec_op_o  out  rvga_op_e  op class (LUI,AUIPC,JAL,JALR,BRANCH,LOAD,STORE,OPIMM,OP,FENCE,SYSTEM,ILLEGAL)
dec_funct3_o  out  3  funct3
dec_funct7b5_o  out  1  instr[30]
rs1_o  out  rvga_reg  source 1 specifier (to rfetch rs1_i)
rs2_o  out  rvga_reg  source 2 specifier (to rfetch rs2_i)
rd_o  out  rvga_reg  destination
rd_w_v_o  out  1  instruction writes rd
imm_o  out  rvga_word  sign-extended immediate
illegal_o  out  1  unrecognised opcode

Behaviour:
- Single-stage registered pipeline with a valid bit plus a data register; decode logic is combinational on fetch_instr_i, captured on accept (fetch_v_i && fetch_ready_o).
- Latency 1 cycle: an instruction accepted at edge N is presented on dec_* after edge N.
- Downstream transfer occurs when dec_v_o && dec_ready_i. While dec_v_o=1 and dec_ready_i=0, all dec_* outputs are held stable.
- Without the optional feature: fetch_ready_o = !dec_v_o || dec_ready_i. Accept and transfer in the same cycle replaces the bundle (full throughput).
- Immediate formats: I, S, B, U, J per RV32I, sign-extended from instr[31]. Shift-immediates use the I-format imm unchanged. R-format, FENCE and SYSTEM give imm=0.
- rd_w_v_o=1 only for LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP with rd!=0. It is 0 for rd=x0, BRANCH, STORE, FENCE, SYSTEM and ILLEGAL.
- rs1/rs2 always carry instr[19:15]/instr[24:20] raw; consumers ignore them when unused.
- Illegal: opcode[1:0]!=2'b11 or an unlisted opcode gives op=ILLEGAL, illegal_o=1, rd_w_v_o=0, imm=0.
- Flush: at the edge where flush_i=1, all valid bits clear. An accept in that same cycle is discarded (flush has priority). fetch_ready_o may still be 1 during flush.
- Reset: dec_v_o=0; all dec_* data, rs1_o, rs2_o and rd_o are 0; op=ILLEGAL encoding 0; illegal_o=0; fetch_ready_o=1 from the first cycle after reset. Reset mid-operation drops everything, the same as flush.

Optional Feature:
RVGA_DECODE_SKID_EN: adds a one-entry skid register so fetch_ready_o = !skid_v, a registered signal with no combinational path from dec_ready_i.
- If the main register is full, not draining, and an accept occurs, the instruction goes to the skid. When the main register drains, the skid moves into it the next cycle; order is preserved.
- Flush clears both entries.
- Without the macro, the combinational ready described above applies.

Decomposition:
- rvga_types package gains rvga_op_e, rvga_opcode constants (7-bit), and a rvga_decoded_s struct (pc, op, funct3, funct7b5, rs1, rs2, rd, rd_w_v, imm, illegal).
- Sub-module rdecode_imm_gen: pure combinational instr -> imm for each format, reused by later stages.

Test Plan:
- Send 0x00500093 (ADDI x1,x0,5) -> next cycle dec_v_o=1, op=OPIMM, rd=1, rs1=0, imm=0x00000005, rd_w_v=1.
- Send 0x12345137 (LUI x2) -> imm=0x12345000, rd=2, rd_w_v=1. Send 0xFE208EE3 (BEQ x1,x2,-4) -> op=BRANCH, rs1=1, rs2=2, imm=0xFFFFFFFC, rd_w_v=0.
- Hold dec_ready_i=0, offer 3 back-to-back instructions -> outputs stable, fetch_ready_o drops (after 1 accepted, or 2 with skid). Release -> all delivered in order, none duplicated or lost.
- Assert flush_i with a bundle held and fetch_v_i=1 -> dec_v_o=0 next cycle, the offered instruction never appears.
- Send 0x00000000 and 0x00000013 with rd=0 -> first: illegal_o=1, rd_w_v=0; second (NOP): op=OPIMM, rd_w_v=0.
- Assert rst_i mid-stream with a valid bundle -> dec_v_o=0 and all outputs 0 next cycle, fetch_ready_o=1.
